// File: rtl/gpio_cond_pkg.sv
// Shared constants and types for the GPIO input conditioner.
// Pure definitions: no latency, no backpressure.
package gpio_cond_pkg;

    localparam int N_IN_DEFAULT        = 14;
    localparam int KEY_LSB             = 0;
    localparam int KEY_W               = 4;
    localparam int SW_LSB              = 4;
    localparam int SW_W                = 10;
    localparam int DEBOUNCE_10MS_25MHZ = 250000;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } deb_state_e;

    // Sized so the counter can hold DEBOUNCE_CYCLES without wrapping.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/gpio_in_conditioner_if.sv
// Board-input / PIO-side signal bundle of the conditioner.
// Wires only: no latency, no backpressure (inputs sampled every cycle).
interface gpio_in_conditioner_if
    import gpio_cond_pkg::*;
#(
    parameter int N_IN = N_IN_DEFAULT
);
    logic [N_IN-1:0] raw_i;
    logic [N_IN-1:0] clear_i;
    logic [31:0]     gpio_o;
    logic [N_IN-1:0] rise_o;
    logic [N_IN-1:0] fall_o;
    logic [N_IN-1:0] pending_o;
    logic            irq_o;

    modport master (
        output raw_i, clear_i,
        input  gpio_o, rise_o, fall_o, pending_o, irq_o
    );

    modport slave (
        input  raw_i, clear_i,
        output gpio_o, rise_o, fall_o, pending_o, irq_o
    );
endinterface

// File: rtl/gpio_debounce_bit.sv
// One input bit: synchronizer, stability counter, debounced level and edge pulses.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES-1 cycles from sampling edge; no backpressure.
module gpio_debounce_bit
    import gpio_cond_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb,
    output logic rise,
    output logic fall
);
    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    deb_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            deb_q   <= RESET_BIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (s != deb_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_d = ST_COUNTING;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_COUNTING: begin
                // Terminal compare ahead of the increment keeps the counter from wrapping.
                if (s == deb_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
        if (accept) begin
            deb_d   = s;
            rise_d  = s;
            fall_d  = ~s;
            state_d = ST_STABLE;
            cnt_d   = '0;
        end
    end

    assign deb  = deb_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// Debounced 32-bit PIO input word with per-bit edge pulses and sticky change flags.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES-1 to gpio_o, +1 to pending/irq; no backpressure.
module gpio_in_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int              N_IN            = N_IN_DEFAULT,
    parameter int              SYNC_STAGES     = 2,
    parameter int              DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ,
    parameter logic [N_IN-1:0] RESET_VAL       = {{(N_IN-KEY_W){1'b0}}, {KEY_W{1'b1}}},
    parameter logic [N_IN-1:0] INV_MASK        = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    gpio_in_conditioner_if.slave bus
);
    logic [N_IN-1:0] deb;
    logic [N_IN-1:0] rise;
    logic [N_IN-1:0] fall;
    logic [N_IN-1:0] pending_q, pending_d;
    logic            irq_q;

    for (genvar i = 0; i < N_IN; i++) begin : g_bit
        gpio_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_BIT      (RESET_VAL[i])
        ) u_bit (
            .clk  (clk),
            .reset(reset),
            .raw  (bus.raw_i[i]),
            .deb  (deb[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    // New edges override a simultaneous clear so no transition is lost.
    always_comb begin
        pending_d = (pending_q & ~bus.clear_i) | rise | fall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            irq_q     <= |pending_d;
        end
    end

    assign bus.gpio_o    = 32'(deb ^ INV_MASK);
    assign bus.rise_o    = rise;
    assign bus.fall_o    = fall;
    assign bus.pending_o = pending_q;
    assign bus.irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench: three conditioner instances (plain, inverted keys, 1-cycle debounce/3-stage sync).
module tb_gpio_in_conditioner;
    import gpio_cond_pkg::*;

    localparam int NI = 14;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    gpio_in_conditioner_if #(.N_IN(NI)) ifa ();
    gpio_in_conditioner_if #(.N_IN(NI)) ifb ();
    gpio_in_conditioner_if #(.N_IN(NI)) ifc ();

    gpio_in_conditioner #(
        .N_IN(NI), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .RESET_VAL(14'h000F), .INV_MASK(14'h0000)
    ) dut_a (.clk(clk), .reset(reset), .bus(ifa));

    gpio_in_conditioner #(
        .N_IN(NI), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .RESET_VAL(14'h000F), .INV_MASK(14'h000F)
    ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    gpio_in_conditioner #(
        .N_IN(NI), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1),
        .RESET_VAL(14'h000F), .INV_MASK(14'h0000)
    ) dut_c (.clk(clk), .reset(reset), .bus(ifc));

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        ifa.raw_i   = 14'h000F;
        ifb.raw_i   = 14'h000F;
        ifc.raw_i   = 14'h000F;
        ifa.clear_i = '0;
        ifb.clear_i = '0;
        ifc.clear_i = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        int         rise_cnt;

        // Reset state held for 20 cycles with keys released.
        do_reset();
        for (int j = 0; j < 20; j++) begin
            step();
            check("rst_gpio_a",  ifa.gpio_o, 32'h0000000F);
            check("rst_edges_a", {ifa.rise_o, ifa.fall_o}, 32'h0);
            check("rst_pend_a",  ifa.pending_o, 32'h0);
            check("rst_irq_a",   ifa.irq_o, 32'h0);
            check("rst_gpio_b",  ifb.gpio_o, 32'h00000000);
            check("rst_gpio_c",  ifc.gpio_o, 32'h0000000F);
        end

        // SW0 clean step 0->1: level after 5 edges, one rise, pending/irq next cycle.
        ifa.raw_i[4] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            check("sw0_gpio", ifa.gpio_o, (j >= 5) ? 32'h0000001F : 32'h0000000F);
            check("sw0_rise", ifa.rise_o, (j == 5) ? 32'h10 : 32'h0);
            check("sw0_fall", ifa.fall_o, 32'h0);
            check("sw0_pend", ifa.pending_o, (j >= 6) ? 32'h10 : 32'h0);
            check("sw0_irq",  ifa.irq_o, (j >= 6) ? 32'h1 : 32'h0);
        end

        // Bouncing SW0: 2-cycle pulses never reach the threshold; single rise after settling.
        do_reset();
        pat      = 8'b0011_0011;
        rise_cnt = 0;
        for (int j = 0; j < 20; j++) begin
            ifa.raw_i[4] = (j < 8) ? pat[j] : 1'b1;
            step();
            if (ifa.rise_o != '0) rise_cnt++;
            check("bounce_rise", ifa.rise_o, (j == 13) ? 32'h10 : 32'h0);
            check("bounce_gpio", ifa.gpio_o, (j >= 13) ? 32'h0000001F : 32'h0000000F);
        end
        check("bounce_rise_count", rise_cnt, 32'd1);

        ifa.clear_i = '1;
        step();
        ifa.clear_i = '0;
        check("clr_all_pend", ifa.pending_o, 32'h0);
        check("clr_all_irq",  ifa.irq_o, 32'h0);

        // KEY0 press; clear colliding with the set loses, the following clear wins.
        ifa.raw_i[0] = 1'b0;
        for (int j = 0; j < 9; j++) begin
            ifa.clear_i[0] = (j == 6) || (j == 7);
            step();
            check("key0_gpio", ifa.gpio_o, (j >= 5) ? 32'h0000001E : 32'h0000001F);
            check("key0_fall", ifa.fall_o, (j == 5) ? 32'h1 : 32'h0);
            check("key0_pend", ifa.pending_o, (j == 6) ? 32'h1 : 32'h0);
            check("key0_irq",  ifa.irq_o, (j == 6) ? 32'h1 : 32'h0);
        end
        ifa.clear_i = '0;

        // Reset in the middle of a count discards it without any pulse.
        do_reset();
        ifa.raw_i[5] = 1'b1;
        for (int j = 0; j < 4; j++) step();
        check("midcnt_cnt", 32'(dut_a.g_bit[5].u_bit.cnt_q), 32'd2);
        reset     = 1'b1;
        ifa.raw_i = 14'h000F;
        step();
        reset = 1'b0;
        check("midrst_cnt", 32'(dut_a.g_bit[5].u_bit.cnt_q), 32'd0);
        for (int j = 0; j < 10; j++) begin
            step();
            check("midrst_gpio",  ifa.gpio_o, 32'h0000000F);
            check("midrst_edges", {ifa.rise_o, ifa.fall_o}, 32'h0);
            check("midrst_pend",  ifa.pending_o, 32'h0);
        end

        // Inverted keys (KEY1 press) and the single-cycle debounce with 3-stage sync (KEY2).
        ifb.raw_i[1] = 1'b0;
        ifc.raw_i[2] = 1'b0;
        for (int j = 0; j < 7; j++) begin
            step();
            check("inv_gpio",   ifb.gpio_o, (j >= 5) ? 32'h00000002 : 32'h00000000);
            check("inv_fall",   ifb.fall_o, (j == 5) ? 32'h2 : 32'h0);
            check("inv_rise",   ifb.rise_o, 32'h0);
            check("deb1_gpio",  ifc.gpio_o, (j >= 3) ? 32'h0000000B : 32'h0000000F);
            check("deb1_fall",  ifc.fall_o, (j == 3) ? 32'h4 : 32'h0);
            check("deb1_pend",  ifc.pending_o, (j >= 4) ? 32'h4 : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_in_conditioner.md
Name: gpio_in_conditioner

Overview:
Input-conditioning stage placed directly upstream of the PIO_IN port of the Qsys system. Raw board inputs (KEY[3:0], SW[9:0]) are asynchronous and bouncy. This block synchronizes them into the 25 MHz core domain, debounces each bit, and produces a clean 32-bit PIO input word. It also provides per-bit rise/fall pulses and a sticky, clearable change flag for interrupt or polling use.

Parameters:
N_IN, 14, number of raw input bits (bits 3:0 are KEY, bits 13:4 are SW).
SYNC_STAGES, 2, flip-flop synchronizer depth per bit; legal range 2..4.
DEBOUNCE_CYCLES, 250000, number of consecutive stable synchronized cycles required to accept a new level (10 ms at 25 MHz); must be at least 1.
RESET_VAL, 14'h000F, debounced level loaded at reset (KEYs released = 1, SWs = 0).
INV_MASK, 14'h0000, per-bit output inversion applied after debouncing; the default keeps raw polarity.

Ports:
clk  in  1  core clock (25 MHz PLL output)
reset  in  1  synchronous, active-high reset
raw_i  in  N_IN  asynchronous board inputs {SW, KEY}
gpio_o  out  32  conditioned word: [N_IN-1:0] = debounced level XOR INV_MASK, [31:N_IN] = 0
rise_o  out  N_IN  one-cycle pulse per bit on an accepted 0->1 transition of debounced level (pre-inversion)
fall_o  out  N_IN  one-cycle pulse per bit on an accepted 1->0 transition (pre-inversion)
pending_o  out  N_IN  sticky per-bit change flags
clear_i  in  N_IN  write-1-to-clear mask for pending_o, sampled every cycle
irq_o  out  1  OR-reduction of pending_o, registered

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - synchronizer flops = RESET_VAL
  - debounced = RESET_VAL, so gpio_o = {0, RESET_VAL ^ INV_MASK}
  - all counters = 0
  - rise_o = fall_o = 0, pending_o = 0, irq_o = 0
- Synchronizer: SYNC_STAGES-deep shift per bit; s = last stage. No logic between stages.
- Per-bit debounce FSM, two states:
  - STABLE: counter = 0. If s != deb, go to COUNTING and set counter = 1.
  - COUNTING:
    - If s == deb, return to STABLE and clear the counter. A bounce restarts the count.
    - Else if counter == DEBOUNCE_CYCLES-1, set deb <= s, pulse rise/fall for one cycle, clear the counter, and go to STABLE.
    - Else counter += 1.
  - DEBOUNCE_CYCLES == 1: deb takes s on the first differing cycle; COUNTING is never held.
- Counter width is clog2(DEBOUNCE_CYCLES+1). The counter never wraps, because the terminal compare precedes increment.
- Latency: a clean raw step sampled at edge k appears on gpio_o after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. rise_o/fall_o assert in the same cycle gpio_o changes.
- pending_o[i]:
  - set in the cycle after rise_o[i] or fall_o[i]
  - cleared by clear_i[i]
  - if set and clear occur in the same cycle, set wins (no lost edges)
- irq_o = registered OR of next-state pending, so it rises together with pending_o.
- Reset mid-count: the counter is discarded and deb returns to RESET_VAL. No pulse is generated by reset itself.
- Simultaneous transitions on multiple bits are independent, with no arbitration.

Decomposition:
- Package gpio_cond_pkg:
  - N_IN_DEFAULT
  - KEY_LSB = 0, KEY_W = 4, SW_LSB = 4, SW_W = 10
  - DEBOUNCE_10MS_25MHZ = 250000
  - function cnt_width(cycles)
- Sub-module gpio_debounce_bit, instantiated N_IN times via generate. It contains the synchronizer, counter, FSM and edge pulses for one bit. Pending/irq logic and output packing stay in the top.

Test Plan (sim with DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset release with raw_i=14'h000F -> gpio_o=32'h0000000F, rise_o=fall_o=0, irq_o=0 for 20 cycles.
- SW0 (raw_i[4]) steps 0->1 and holds -> gpio_o[4]=1 exactly 5 cycles after the first sampling edge; rise_o[4] high for exactly 1 cycle; pending_o[4]=1 next cycle; irq_o=1.
- raw_i[4] toggles 1,0,1,0 every 2 cycles, then settles at 1 -> no rise_o until 4 consecutive stable synchronized cycles after the final toggle; exactly one rise pulse.
- KEY0 (raw_i[0]) 1->0 held; clear_i[0] pulsed in the same cycle the pending flag would set -> pending_o[0] stays 1 (set wins); a clear_i[0] pulse one cycle later -> pending_o[0]=0, irq_o=0.
- raw_i held differing for 2 cycles (mid-count), then reset asserted for 1 cycle -> gpio_o returns to RESET_VAL, no fall_o/rise_o, counters at 0.
- INV_MASK=14'h000F, reset -> gpio_o=32'h00000000; KEY1 pressed (raw 0, held) -> gpio_o[1]=1 and fall_o[1] pulses.
